axi4_mem_responder: RTL

- AXI4 slave (responder) backed by an on-chip word array. It stands in for the MIG/DDR controller in simulation and in small-memory builds.
- Presents the same AXI4_Std interface and mig_init_done handshake that the MIG adapter master consumes.
- One write burst and one read burst in flight at a time, on independent channels.
- INCR bursts of 32-bit words.

---
 rtl/axi4_mem_responder_if.sv | 73 +++++++
 rtl/axi4_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_responder_if.sv
// AXI4_Std bus bundle: AW/W/B/AR/R channels, 32-bit data and address.
// The responder connects through the slave modport, the bus driver through master.
interface AXI4_Std #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [3:0]      awqos;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic [3:0]      arqos;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 INCR-burst slave backed by a 32-bit word array, standing in for the DDR controller.
// Define AXI_RESPONDER_WSTRB_EN to honour wstrb per byte lane; by default all bytes are written.
module axi4_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int INIT_CYCLES = 64,
    parameter int MAX_BURST   = 256,
    parameter int ID_W        = 4
) (
    input  logic     clk,
    input  logic     reset,
    output logic     init_done,
    AXI4_Std.slave   axi
);
    localparam int          IW       = $clog2(DEPTH_WORDS);
    localparam int          CW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam logic [31:0] INIT_LIM = INIT_CYCLES;
    localparam logic [31:0] MAX_B    = MAX_BURST;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic [CW-1:0]   r_init_cnt;
    logic            r_init_done;

    wstate_t         r_wstate;
    logic [IW-1:0]   r_widx;
    logic [7:0]      r_wlen;
    logic [7:0]      r_wbeat;
    logic [ID_W-1:0] r_wid;
    logic            r_werr;
    logic            r_wovr;
    logic            r_wready;
    logic            r_bvalid;
    logic [ID_W-1:0] r_bid;
    logic [1:0]      r_bresp;

    rstate_t         r_rstate;
    logic [IW-1:0]   r_ridx;
    logic [7:0]      r_rlen;
    logic [7:0]      r_rbeat;
    logic            r_rvalid;
    logic            r_rlast;
    logic [ID_W-1:0] r_rid;
    logic [1:0]      r_rresp;
    logic [31:0]     r_rdata;

    logic            w_aw_fire;
    logic            w_w_fire;
    logic            w_ar_fire;
    logic            w_r_fire;
    logic [IW-1:0]   w_rnext_idx;
    logic            w_unused;

    assign init_done   = r_init_done;
    assign axi.awready = r_init_done && (r_wstate == W_IDLE);
    assign axi.arready = r_init_done && (r_rstate == R_IDLE);
    assign axi.wready  = r_wready;
    assign axi.bvalid  = r_bvalid;
    assign axi.bid     = r_bid;
    assign axi.bresp   = r_bresp;
    assign axi.rvalid  = r_rvalid;
    assign axi.rlast   = r_rlast;
    assign axi.rid     = r_rid;
    assign axi.rresp   = r_rresp;
    assign axi.rdata   = r_rdata;

    assign w_aw_fire   = axi.awvalid && axi.awready;
    assign w_w_fire    = axi.wvalid && r_wready;
    assign w_ar_fire   = axi.arvalid && axi.arready;
    assign w_r_fire    = r_rvalid && axi.rready;
    assign w_rnext_idx = r_ridx + 1'b1;

    // Attribute fields a plain INCR word store has no use for.
    assign w_unused = &{1'b0, axi.awaddr, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                        axi.awprot, axi.awqos, axi.araddr, axi.arsize, axi.arburst, axi.arlock,
                        axi.arcache, axi.arprot, axi.arqos, axi.wstrb};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else if (!r_init_done) begin
            if ({{(32-CW){1'b0}}, r_init_cnt} + 32'd1 >= INIT_LIM) r_init_done <= 1'b1;
            else                                                   r_init_cnt  <= r_init_cnt + 1'b1;
        end
    end

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_w_fire) begin
`ifdef AXI_RESPONDER_WSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) r_mem[r_widx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
`else
            r_mem[r_widx] <= axi.wdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wstate <= W_IDLE;
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wbeat  <= '0;
            r_wid    <= '0;
            r_werr   <= 1'b0;
            r_wovr   <= 1'b0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_aw_fire) begin
                    r_widx   <= axi.awaddr[2 +: IW];
                    r_wlen   <= axi.awlen;
                    r_wbeat  <= '0;
                    r_wid    <= axi.awid;
                    r_werr   <= 1'b0;
                    r_wovr   <= ({24'd0, axi.awlen} + 32'd1) > MAX_B;
                    r_wready <= 1'b1;
                    r_wstate <= W_DATA;
                end
                W_DATA: if (w_w_fire) begin
                    r_widx  <= r_widx + 1'b1;
                    r_wbeat <= r_wbeat + 1'b1;
                    // Burst length comes from awlen; wlast only flags protocol errors.
                    if (r_wbeat == r_wlen) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bid    <= r_wid;
                        r_bresp  <= (r_werr || r_wovr || !axi.wlast) ? 2'b10 : 2'b00;
                        r_wstate <= W_RESP;
                    end else if (axi.wlast) begin
                        r_werr <= 1'b1;
                    end
                end
                W_RESP: if (axi.bready) begin
                    r_bvalid <= 1'b0;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_ar_fire) begin
                    r_ridx   <= axi.araddr[2 +: IW];
                    r_rdata  <= r_mem[axi.araddr[2 +: IW]];
                    r_rlen   <= axi.arlen;
                    r_rbeat  <= '0;
                    r_rid    <= axi.arid;
                    r_rresp  <= (({24'd0, axi.arlen} + 32'd1) > MAX_B) ? 2'b10 : 2'b00;
                    r_rlast  <= (axi.arlen == 8'd0);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: if (w_r_fire) begin
                    if (r_rbeat == r_rlen) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        r_rstate <= R_IDLE;
                    end else begin
                        r_ridx  <= w_rnext_idx;
                        r_rdata <= r_mem[w_rnext_idx];
                        r_rbeat <= r_rbeat + 1'b1;
                        r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule
